seq_lane_shifter: RTL and testbench
===================================

// Module: seq_lane_shifter
// PURPOSE
//  Multi-lane iterative shifter: SETS lanes of WIDTH bits shift in parallel, one bit position per clock.
//  Supports logical, arithmetic and rotate modes in both directions, and captures the shifted-out bits per lane.
//  Uses a valid/ready handshake on both input and output.
//  Sits behind the ALU operand mux as the sequential replacement for the combinational packed shifter.
// PARAMETERS
//  WIDTH  8  bits per lane; must be >= 2
//  SETS   2  number of independent lanes
//  AW     $clog2(WIDTH)+1  per-lane shift-amount width (derived); values 0..2^AW-1 are legal
// PORTS
//  clk              in   1           rising-edge clock
//  rst              in   1           asynchronous, active-high reset
//  in_valid         in   1           request valid
//  in_ready         out  1           block can accept a request
//  in_packed        in   SETS*WIDTH  operands; lane i = [i*WIDTH +: WIDTH]
//  amt_packed       in   SETS*AW     shift amounts; lane i = [i*AW +: AW]
//  dir              in   1           0 = left, 1 = right; applies to all lanes
//  mode             in   2           00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
//  out_valid        out  1           result valid
//  out_ready        in   1           consumer accepts result
//  out_packed       out  SETS*WIDTH  shifted results
//  overflow_packed  out  SETS*WIDTH  bits shifted out per lane
//  busy             out  1           high in BUSY and DONE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, all data/overflow/count regs=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: in_ready=1. When in_valid=1 on an edge, latch operands, dir and mode.
//    Load each lane counter with its effective amount (below).
//    Go to BUSY if any counter is nonzero; otherwise go to DONE.
//   BUSY: each lane with count>0 shifts one position and decrements its count; lanes at 0 hold.
//    Go to DONE on the edge where every counter reaches 0.
//   DONE: out_valid=1; outputs are stable while waiting. On out_valid&&out_ready go to IDLE.
//    No new request is accepted in DONE.
//  Latency: accept edge + max(eff_amt) BUSY cycles, then out_valid.
//   All amounts 0 => out_valid rises in the cycle after accept.
//   Throughput is one request per (max_amt + 2) cycles minimum.
//  Effective amount:
//   Logical and arithmetic modes: min(amt, WIDTH).
//    Amounts >= WIDTH yield 0 (logical, or arithmetic left) or all sign bits (arithmetic right).
//   Rotate mode: amt mod WIDTH.
//  Per-step rules, data d and overflow o:
//   Left, logical or arithmetic: d={d[W-2:0],0};   o={o[W-2:0],d[W-1]}
//   Right, logical:              d={0,d[W-1:1]};   o={d[0],o[W-1:1]}
//   Right, arithmetic:           d={d[W-1],d[W-1:1]}; o as for logical right
//   Rotate left:                 d={d[W-2:0],d[W-1]}; o unchanged (stays 0)
//   Rotate right:                d={d[0],d[W-1:1]};   o unchanged (stays 0)
//  Overflow order:
//   Left shifts: the shifted-out bits sit in o's LSBs in original order.
//   Right shifts: the shifted-out bits sit in o's MSBs in original order.
//  in_valid is ignored outside IDLE. out_ready is ignored unless out_valid=1.
//  Operand inputs are sampled only on the accept edge; later changes to them have no effect.
//  Reset asserted mid-BUSY or mid-DONE aborts the operation. No output is produced for it.
// STRUCTURE
//  Shared package alu_pkg:
//   mode constants SHIFT_LOGICAL/SHIFT_ARITH/SHIFT_ROTATE
//   FSM state encoding (IDLE/BUSY/DONE)
//   AW width function
//  Sub-module shift_lane:
//   one lane's data, overflow and count registers plus its step logic
//   outputs lane_done
//   instantiated SETS times via generate
//  Top level: the FSM, the AND-reduction of lane_done, and packing/unpacking.
// TESTING (WIDTH=8, SETS=2)
//  1. Lane0=0x96, amt 3, right, logical -> out 0x12, ovf 0xC0, out_valid 4 cycles after accept.
//  2. Lane0=0x96, amt 3, right, arith -> out 0xF2, ovf 0xC0.
//     Lane1=0x96, amt 2, left, logical -> out 0x58, ovf 0x02.
//  3. Rotate: 0x96 left by 2 -> 0x5A; 0x96 right by 12 -> 0x69, ovf 0.
//     Both lanes finish when the longer count (4) is done.
//  4. Amounts 0,0 -> out_valid in the cycle after accept, data unchanged.
//     Amount 9, logical left -> 0x00, ovf = input.
//  5. Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
//     in_valid pulses during BUSY are ignored.
//  6. Assert rst mid-BUSY -> next cycle in_ready=1, out_valid=0, regs 0.
//     A fresh request then completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module  : alu_pkg
//  Brief   : Shared ALU shifter constants, FSM state encoding, width helper.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [1:0] SHIFT_LOGICAL = 2'b00;
    localparam logic [1:0] SHIFT_ARITH   = 2'b01;
    localparam logic [1:0] SHIFT_ROTATE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_aw(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_lane_shifter_if.sv
// ============================================================================
//  Module  : seq_lane_shifter_if
//  Brief   : Request/response handshake bundle for the sequential lane shifter.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_lane_shifter_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SETS  = 2,
    parameter int AW    = calc_aw(WIDTH)
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [SETS*WIDTH-1:0] in_packed;
    logic [SETS*AW-1:0]    amt_packed;
    logic                  dir;
    logic [1:0]            mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [SETS*WIDTH-1:0] out_packed;
    logic [SETS*WIDTH-1:0] overflow_packed;
    logic                  busy;

    modport master (
        output in_valid, in_packed, amt_packed, dir, mode, out_ready,
        input  in_ready, out_valid, out_packed, overflow_packed, busy
    );

    modport slave (
        input  in_valid, in_packed, amt_packed, dir, mode, out_ready,
        output in_ready, out_valid, out_packed, overflow_packed, busy
    );

endinterface

`default_nettype wire

// File: rtl/shift_lane.sv
// ============================================================================
//  Module  : shift_lane
//  Brief   : One lane of the iterative shifter: data/overflow/count and step.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_lane
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = calc_aw(WIDTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic             step,
    input  wire logic [WIDTH-1:0] load_data,
    input  wire logic [AW-1:0]    load_amt,
    input  wire logic [1:0]       load_mode,
    input  wire logic             dir,
    input  wire logic [1:0]       mode,
    output logic      [WIDTH-1:0] data,
    output logic      [WIDTH-1:0] ovf,
    output logic                  lane_done,
    output logic                  load_zero
);

    localparam logic [AW-1:0] c_width = AW'(WIDTH);
    localparam logic [AW-1:0] c_one   = AW'(1);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_ovf;
    logic [AW-1:0]    r_count;
    logic [AW-1:0]    w_eff_amt;
    logic [WIDTH-1:0] w_data_step;
    logic [WIDTH-1:0] w_ovf_step;

    always_comb begin
        w_eff_amt = load_amt;
        if (load_mode == SHIFT_ROTATE) begin
            w_eff_amt = load_amt % c_width;
        end else if (load_amt > c_width) begin
            w_eff_amt = c_width;
        end
    end

    // Rotates never touch the overflow register, so it stays at its load value of zero.
    always_comb begin
        w_data_step = r_data;
        w_ovf_step  = r_ovf;
        if (mode == SHIFT_ROTATE) begin
            w_data_step = dir ? {r_data[0], r_data[WIDTH-1:1]}
                              : {r_data[WIDTH-2:0], r_data[WIDTH-1]};
        end else if (dir) begin
            w_data_step = {(mode == SHIFT_ARITH) && r_data[WIDTH-1], r_data[WIDTH-1:1]};
            w_ovf_step  = {r_data[0], r_ovf[WIDTH-1:1]};
        end else begin
            w_data_step = {r_data[WIDTH-2:0], 1'b0};
            w_ovf_step  = {r_ovf[WIDTH-2:0], r_data[WIDTH-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_ovf   <= '0;
            r_count <= '0;
        end else if (load) begin
            r_data  <= load_data;
            r_ovf   <= '0;
            r_count <= w_eff_amt;
        end else if (step && (r_count != '0)) begin
            r_data  <= w_data_step;
            r_ovf   <= w_ovf_step;
            r_count <= r_count - c_one;
        end
    end

    assign data      = r_data;
    assign ovf       = r_ovf;
    // High when the count is zero after the current step edge.
    assign lane_done = (r_count <= c_one);
    assign load_zero = (w_eff_amt == '0);

endmodule

`default_nettype wire

// File: rtl/seq_lane_shifter.sv
// ============================================================================
//  Module  : seq_lane_shifter
//  Brief   : Multi-lane iterative shifter with valid/ready on both sides.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_lane_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SETS  = 2,
    parameter int AW    = calc_aw(WIDTH)
) (
    input wire logic          clk,
    input wire logic          rst,
    seq_lane_shifter_if.slave bus
);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_dir;
    logic [1:0]            r_mode;
    logic                  w_load;
    logic                  w_step;
    logic [SETS-1:0]       w_lane_done;
    logic [SETS-1:0]       w_lane_zero;
    logic [SETS*WIDTH-1:0] w_out_packed;
    logic [SETS*WIDTH-1:0] w_ovf_packed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_dir   <= 1'b0;
            r_mode  <= SHIFT_LOGICAL;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_dir  <= bus.dir;
                r_mode <= bus.mode;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_load       = 1'b1;
                    w_next_state = (&w_lane_zero) ? DONE : BUSY;
                end
            end
            BUSY: begin
                w_step = 1'b1;
                if (&w_lane_done) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    for (genvar g = 0; g < SETS; g++) begin : g_lane
        shift_lane #(
            .WIDTH (WIDTH),
            .AW    (AW)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (w_load),
            .step      (w_step),
            .load_data (bus.in_packed[g*WIDTH +: WIDTH]),
            .load_amt  (bus.amt_packed[g*AW +: AW]),
            .load_mode (bus.mode),
            .dir       (r_dir),
            .mode      (r_mode),
            .data      (w_out_packed[g*WIDTH +: WIDTH]),
            .ovf       (w_ovf_packed[g*WIDTH +: WIDTH]),
            .lane_done (w_lane_done[g]),
            .load_zero (w_lane_zero[g])
        );
    end

    assign bus.in_ready        = (r_state == IDLE);
    assign bus.out_valid       = (r_state == DONE);
    assign bus.busy            = (r_state != IDLE);
    assign bus.out_packed      = w_out_packed;
    assign bus.overflow_packed = w_ovf_packed;

endmodule

`default_nettype wire

// File: tb/tb_seq_lane_shifter.sv
// ============================================================================
//  Module  : tb_seq_lane_shifter
//  Brief   : Self-checking bench for seq_lane_shifter (WIDTH=8, SETS=2).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_lane_shifter;
    import alu_pkg::*;

    localparam int WIDTH = 8;
    localparam int SETS  = 2;
    localparam int AW    = calc_aw(WIDTH);
    localparam int DW    = SETS * WIDTH;
    localparam int MW    = SETS * AW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_lane_shifter_if #(.WIDTH(WIDTH), .SETS(SETS), .AW(AW)) bus ();

    seq_lane_shifter #(.WIDTH(WIDTH), .SETS(SETS), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] din;
        logic [MW-1:0] amt;
        bit            dir;
        logic [1:0]    mode;
        logic [DW-1:0] exp_out;
        logic [DW-1:0] exp_ovf;
        int            exp_lat;
    } vec_t;

    vec_t vecs [10];

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] got_out, got_ovf, e_out, e_ovf;
    int            got_lat, e_lat;
    int            seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-lane arithmetic on integers, no stepping.
    function automatic void model_lane(input int x, input int a, input bit d, input logic [1:0] m,
                                       output int o, output int v, output int k);
        int mask;
        mask = (1 << WIDTH) - 1;
        if (m == SHIFT_ROTATE) begin
            k = a % WIDTH;
            o = d ? (((x >> k) | (x << (WIDTH - k))) & mask)
                  : (((x << k) | (x >> (WIDTH - k))) & mask);
            v = 0;
        end else begin
            k = (a < WIDTH) ? a : WIDTH;
            if (!d) begin
                o = (x << k) & mask;
                v = x >> (WIDTH - k);
            end else begin
                o = x >> k;
                if (m == SHIFT_ARITH && x[WIDTH-1]) o = o | ((mask << (WIDTH - k)) & mask);
                v = (x << (WIDTH - k)) & mask;
            end
        end
    endfunction

    function automatic void model(input logic [DW-1:0] din, input logic [MW-1:0] amt, input bit d,
                                  input logic [1:0] m, output logic [DW-1:0] eo,
                                  output logic [DW-1:0] ev, output int lat);
        int o, v, k;
        eo  = '0;
        ev  = '0;
        lat = 0;
        for (int i = 0; i < SETS; i++) begin
            model_lane(int'(din[i*WIDTH +: WIDTH]), int'(amt[i*AW +: AW]), d, m, o, v, k);
            eo[i*WIDTH +: WIDTH] = WIDTH'(o);
            ev[i*WIDTH +: WIDTH] = WIDTH'(v);
            if (k > lat) lat = k;
        end
    endfunction

    task automatic accept(input logic [DW-1:0] din, input logic [MW-1:0] amt, input bit d,
                          input logic [1:0] m);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid   = 1'b1;
        bus.in_packed  = din;
        bus.amt_packed = amt;
        bus.dir        = d;
        bus.mode       = m;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.in_packed  = DW'($urandom);
        bus.amt_packed = MW'($urandom);
        bus.dir        = 1'($urandom);
        bus.mode       = 2'($urandom);
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic release_out(input int hold);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_req(input logic [DW-1:0] din, input logic [MW-1:0] amt, input bit d,
                           input logic [1:0] m, input int hold, output logic [DW-1:0] o,
                           output logic [DW-1:0] v, output int lat);
        accept(din, amt, d, m);
        wait_done(0, lat);
        o = bus.out_packed;
        v = bus.overflow_packed;
        release_out(hold);
    endtask

    initial begin
        vecs[0] = '{16'h0096, 8'h03, 1'b1, SHIFT_LOGICAL, 16'h0012, 16'h00C0, 3};
        vecs[1] = '{16'h9696, 8'h23, 1'b1, SHIFT_ARITH,   16'hE5F2, 16'h80C0, 3};
        vecs[2] = '{16'h9696, 8'h22, 1'b0, SHIFT_LOGICAL, 16'h5858, 16'h0202, 2};
        vecs[3] = '{16'h9696, 8'hC2, 1'b0, SHIFT_ROTATE,  16'h695A, 16'h0000, 4};
        vecs[4] = '{16'h9696, 8'hC2, 1'b1, SHIFT_ROTATE,  16'h69A5, 16'h0000, 4};
        vecs[5] = '{16'hA53C, 8'h00, 1'b0, SHIFT_ARITH,   16'hA53C, 16'h0000, 0};
        vecs[6] = '{16'hFF96, 8'hF9, 1'b0, SHIFT_LOGICAL, 16'h0000, 16'hFF96, 8};
        vecs[7] = '{16'h807F, 8'hFF, 1'b1, SHIFT_ARITH,   16'hFF00, 16'h807F, 8};
        vecs[8] = '{16'h8181, 8'h11, 1'b0, 2'b11,         16'h0202, 16'h0101, 1};
        vecs[9] = '{16'h1234, 8'h88, 1'b0, SHIFT_ROTATE,  16'h1234, 16'h0000, 0};

        bus.in_valid   = 1'b0;
        bus.in_packed  = '0;
        bus.amt_packed = '0;
        bus.dir        = 1'b0;
        bus.mode       = SHIFT_LOGICAL;
        bus.out_ready  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready",  64'(bus.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_busy",      64'(bus.busy), 64'd0);
        check("reset_out",       64'(bus.out_packed), 64'd0);
        check("reset_ovf",       64'(bus.overflow_packed), 64'd0);

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].din, vecs[i].amt, vecs[i].dir, vecs[i].mode, i % 3,
                    got_out, got_ovf, got_lat);
            check($sformatf("vec%0d_out", i), 64'(got_out), 64'(vecs[i].exp_out));
            check($sformatf("vec%0d_ovf", i), 64'(got_ovf), 64'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_lat", i), 64'(got_lat), 64'(vecs[i].exp_lat));
        end

        // Backpressure in DONE and stray in_valid during BUSY/DONE.
        accept(16'h9696, 8'h35, 1'b1, SHIFT_LOGICAL);
        bus.in_valid   = 1'b1;
        bus.in_packed  = 16'h0000;
        bus.amt_packed = 8'h00;
        check("busy_in_ready", 64'(bus.in_ready), 64'd0);
        check("busy_flag",     64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        wait_done(1, got_lat);
        check("hold_lat", 64'(got_lat), 64'd5);
        for (int c = 0; c < 5; c++) begin
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
            check("hold_in_ready",  64'(bus.in_ready), 64'd0);
            check("hold_out",       64'(bus.out_packed), 64'h1204);
            check("hold_ovf",       64'(bus.overflow_packed), 64'hC0B0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        release_out(0);
        check("post_in_ready",  64'(bus.in_ready), 64'd1);
        check("post_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        check("post_busy", 64'(bus.busy), 64'd0);

        // Asynchronous reset in the middle of an operation.
        accept(16'hFFFF, 8'h88, 1'b0, SHIFT_LOGICAL);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_in_ready",  64'(bus.in_ready), 64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_busy",      64'(bus.busy), 64'd0);
        check("abort_out",       64'(bus.out_packed), 64'd0);
        check("abort_ovf",       64'(bus.overflow_packed), 64'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("abort_no_output", 64'(seen), 64'd0);
        run_req(vecs[1].din, vecs[1].amt, vecs[1].dir, vecs[1].mode, 1, got_out, got_ovf, got_lat);
        check("fresh_out", 64'(got_out), 64'(vecs[1].exp_out));
        check("fresh_ovf", 64'(got_ovf), 64'(vecs[1].exp_ovf));
        check("fresh_lat", 64'(got_lat), 64'(vecs[1].exp_lat));

        // Randomized traffic against the reference model.
        for (int r = 0; r < 150; r++) begin
            logic [DW-1:0] din;
            logic [MW-1:0] amt;
            bit            d;
            logic [1:0]    m;
            din = DW'($urandom);
            amt = MW'($urandom);
            d   = 1'($urandom);
            m   = 2'($urandom);
            model(din, amt, d, m, e_out, e_ovf, e_lat);
            run_req(din, amt, d, m, $urandom_range(0, 3), got_out, got_ovf, got_lat);
            check("rand_out", 64'(got_out), 64'(e_out));
            check("rand_ovf", 64'(got_ovf), 64'(e_ovf));
            check("rand_lat", 64'(got_lat), 64'(e_lat));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
